bec_axil_wrapper: RTL and testbench

// - AXI4-Lite slave register front-end for the 163-bit binary-Edwards-curve (BEC) scalar-multiply core.
// - Collects a 163-bit key from six 32-bit writes and starts the core.
// - Captures the core's W/Z results and returns them over six 32-bit reads each.
// - Sits at base 0xC000_0000 behind the system AXI interconnect; the core is attached through the core_* ports.

---
 rtl/bec_pkg.sv | 28 ++
 rtl/bec_axil_wrapper_axil_slave_if.sv | 68 ++++++
 rtl/bec_axil_wrapper.sv | 165 ++++++++++++++++
 tb/tb_bec_axil_wrapper.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bec_pkg.sv
// Shared widths, register offsets and word-slicing helper for the BEC AXI-Lite front-end.
package bec_pkg;

  localparam int KEY_W  = 163;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NWORDS = (KEY_W + DATA_W - 1) / DATA_W;

  localparam logic [ADDR_W-1:0] ENABLE_OFS = 5'h00;
  localparam logic [ADDR_W-1:0] KEY_OFS    = 5'h04;
  localparam logic [ADDR_W-1:0] NEXT_K_OFS = 5'h08;
  localparam logic [ADDR_W-1:0] WOUT_OFS   = 5'h0C;
  localparam logic [ADDR_W-1:0] ZOUT_OFS   = 5'h10;
  localparam logic [ADDR_W-1:0] DONE_OFS   = 5'h14;

  typedef logic [KEY_W-1:0] bec_word_t;
  typedef logic [2:0]       word_idx_t;

  localparam word_idx_t LAST_WORD = word_idx_t'(NWORDS - 1);

  // Zero-extends to a whole number of bus words so the top word reads {29'b0, v[162:160]}.
  function automatic logic [DATA_W-1:0] word_sel(input bec_word_t v, input word_idx_t idx);
    logic [NWORDS*DATA_W-1:0] ext;
    ext = {{(NWORDS*DATA_W-KEY_W){1'b0}}, v};
    return ext[int'(idx)*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/bec_axil_wrapper_axil_slave_if.sv
// AXI4-Lite slave handshake: one write and one read outstanding, registered ready/valid.
module axil_slave_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data
);

  assign wr_en   = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
  assign wr_addr = s_axi_awaddr;
  assign wr_data = s_axi_wdata;
  assign rd_en   = s_axi_arready && s_axi_arvalid;
  assign rd_addr = s_axi_araddr;

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;

  // Ready is a single-cycle pulse; the !ready term stops a back-to-back re-accept of the same beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
    end else begin
      s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      if (wr_en)
        s_axi_bvalid <= 1'b1;
      else if (s_axi_bready)
        s_axi_bvalid <= 1'b0;

      s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
      if (rd_en) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bec_axil_wrapper.sv
// AXI4-Lite register front-end for the 163-bit BEC scalar-multiply core:
// assembles the key, starts the core, and serves W/Z results word by word.
module bec_axil_wrapper
  import bec_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int KEY_W  = 163
) (
  input  logic              aclk_0,
  input  logic              areset_0,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              core_start,
  output logic [KEY_W-1:0]  core_key,
  input  logic              core_done,
  input  logic [KEY_W-1:0]  core_wout,
  input  logic [KEY_W-1:0]  core_zout
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] wr_ofs;
  logic [ADDR_W-1:0] rd_ofs;

  logic      enable;
  logic      done_flag;
  word_idx_t kcnt;
  word_idx_t wptr;
  word_idx_t zptr;
  bec_word_t key_r;
  bec_word_t wout_r;
  bec_word_t zout_r;

  logic unused_ok;

  axil_slave_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_axil (
    .aclk          (aclk_0),
    .areset        (areset_0),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  // Registers are word-aligned; byte-lane bits of the address are don't-care.
  assign wr_ofs = {wr_addr[ADDR_W-1:2], 2'b00};
  assign rd_ofs = {rd_addr[ADDR_W-1:2], 2'b00};

  assign core_key  = key_r;
  assign unused_ok = ^{s_axi_wstrb, s_axi_awprot, s_axi_arprot, wr_addr[1:0], rd_addr[1:0]};

  always_comb begin
    rd_data = '0;
    case (rd_ofs)
      ENABLE_OFS: rd_data = {{(DATA_W-1){1'b0}}, enable};
      WOUT_OFS:   rd_data = word_sel(wout_r, wptr);
      ZOUT_OFS:   rd_data = word_sel(zout_r, zptr);
      DONE_OFS:   rd_data = {{(DATA_W-1){1'b0}}, done_flag};
      default:    rd_data = '0;
    endcase
  end

  // Statement order sets priority: read-advance < result capture < ENABLE clear / key completion.
  always_ff @(posedge aclk_0) begin
    if (areset_0) begin
      enable     <= 1'b0;
      done_flag  <= 1'b0;
      kcnt       <= '0;
      wptr       <= '0;
      zptr       <= '0;
      key_r      <= '0;
      wout_r     <= '0;
      zout_r     <= '0;
      core_start <= 1'b0;
    end else begin
      core_start <= 1'b0;

      if (rd_en && rd_ofs == WOUT_OFS)
        wptr <= (wptr == LAST_WORD) ? '0 : wptr + 3'd1;
      if (rd_en && rd_ofs == ZOUT_OFS)
        zptr <= (zptr == LAST_WORD) ? '0 : zptr + 3'd1;

      if (core_done && enable) begin
        wout_r    <= core_wout;
        zout_r    <= core_zout;
        done_flag <= 1'b1;
        wptr      <= '0;
        zptr      <= '0;
      end

      if (wr_en) begin
        case (wr_ofs)
          ENABLE_OFS: begin
            enable <= wr_data[0];
            if (!wr_data[0]) begin
              kcnt      <= '0;
              done_flag <= 1'b0;
              wptr      <= '0;
              zptr      <= '0;
            end
          end
          KEY_OFS: begin
            if (enable) begin
              if (kcnt == LAST_WORD) begin
                key_r[KEY_W-1:(NWORDS-1)*DATA_W] <= wr_data[KEY_W-(NWORDS-1)*DATA_W-1:0];
                kcnt       <= '0;
                done_flag  <= 1'b0;
                core_start <= 1'b1;
              end else begin
                key_r[int'(kcnt)*DATA_W +: DATA_W] <= wr_data;
                kcnt <= kcnt + 3'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bec_axil_wrapper.sv
// Scoreboard bench for bec_axil_wrapper: directed AXI-Lite traffic, monitor pops expected R/B beats.
module tb_bec_axil_wrapper;
  import bec_pkg::*;

  logic              aclk_0 = 1'b0;
  logic              areset_0 = 1'b1;
  logic [4:0]        s_axi_awaddr = '0;
  logic [2:0]        s_axi_awprot = '0;
  logic              s_axi_awvalid = 1'b0;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata = '0;
  logic [3:0]        s_axi_wstrb = 4'hF;
  logic              s_axi_wvalid = 1'b0;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready = 1'b1;
  logic [4:0]        s_axi_araddr = '0;
  logic [2:0]        s_axi_arprot = '0;
  logic              s_axi_arvalid = 1'b0;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready = 1'b1;
  logic              core_start;
  logic [162:0]      core_key;
  logic              core_done = 1'b0;
  logic [162:0]      core_wout = '0;
  logic [162:0]      core_zout = '0;

  int checks = 0;
  int errors = 0;
  int start_count = 0;
  bit pulse_done_at_hs = 1'b0;
  logic [31:0] rq[$];
  logic [1:0]  bq[$];

  bec_axil_wrapper dut (
    .aclk_0        (aclk_0),
    .areset_0      (areset_0),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .core_start    (core_start),
    .core_key      (core_key),
    .core_done     (core_done),
    .core_wout     (core_wout),
    .core_zout     (core_zout)
  );

  always #5 aclk_0 = ~aclk_0;

  // Monitor: pops the scoreboard whenever a beat completes on R or B.
  always @(negedge aclk_0) begin
    logic [31:0] rexp;
    logic [1:0]  bexp;
    if (!areset_0 && s_axi_rvalid && s_axi_rready) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected: got rdata=%h, required no beat", s_axi_rdata);
      end else begin
        rexp = rq.pop_front();
        if (s_axi_rdata !== rexp || s_axi_rresp !== 2'b00) begin
          errors++;
          $display("FAIL r_beat: got rdata=%h rresp=%b, required rdata=%h rresp=00",
                   s_axi_rdata, s_axi_rresp, rexp);
        end
      end
    end
    if (!areset_0 && s_axi_bvalid && s_axi_bready) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got bresp=%b, required no beat", s_axi_bresp);
      end else begin
        bexp = bq.pop_front();
        if (s_axi_bresp !== bexp) begin
          errors++;
          $display("FAIL b_beat: got bresp=%b, required %b", s_axi_bresp, bexp);
        end
      end
    end
    if (core_start) start_count++;
  end

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, required handshake", name);
  endtask

  task automatic wait_awready(input string name);
    int n = 0;
    do begin @(negedge aclk_0); n++; end while (!s_axi_awready && n < 50);
    if (!s_axi_awready) timeout(name);
  endtask

  task automatic wait_arready(input string name);
    int n = 0;
    do begin @(negedge aclk_0); n++; end while (!s_axi_arready && n < 50);
    if (!s_axi_arready) timeout(name);
  endtask

  task automatic wait_b_clear();
    int n = 0;
    do begin @(negedge aclk_0); n++; end while (s_axi_bvalid && n < 50);
    if (s_axi_bvalid) timeout("bvalid_clear");
  endtask

  task automatic wait_r_clear();
    int n = 0;
    do begin @(negedge aclk_0); n++; end while (s_axi_rvalid && n < 50);
    if (s_axi_rvalid) timeout("rvalid_clear");
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d);
    bq.push_back(2'b00);
    s_axi_awaddr = a; s_axi_wdata = d;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    wait_awready("aw_accept");
    if (pulse_done_at_hs) core_done = 1'b1;
    @(posedge aclk_0); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; core_done = 1'b0;
    wait_b_clear();
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] exp);
    rq.push_back(exp);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    wait_arready("ar_accept");
    if (pulse_done_at_hs) core_done = 1'b1;
    @(posedge aclk_0); #1;
    s_axi_arvalid = 1'b0; core_done = 1'b0;
    wait_r_clear();
  endtask

  task automatic pulse_done(input logic [162:0] w, input logic [162:0] z);
    @(posedge aclk_0); #1;
    core_wout = w; core_zout = z; core_done = 1'b1;
    @(posedge aclk_0); #1;
    core_done = 1'b0;
  endtask

  localparam logic [162:0] KEY_A = {3'h7, 32'h55555555, 32'h44444444, 32'h33333333,
                                    32'h22222222, 32'h11111111};
  localparam logic [162:0] KEY_B = {3'h5, 32'h11121314, 32'h0D0E0F10, 32'h090A0B0C,
                                    32'h05060708, 32'h01020304};
  localparam logic [162:0] W2    = {3'h6, 32'hA5A50004, 32'hA5A50003, 32'hA5A50002,
                                    32'hA5A50001, 32'hA5A50000};

  initial begin
    logic [31:0] key_a_words [6];
    logic [31:0] key_b_words [6];
    logic [31:0] hold_rdata;
    int s0;
    key_a_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h7};
    key_b_words = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314, 32'h5};

    repeat (2) @(posedge aclk_0);
    #1 areset_0 = 1'b0;
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_core_key", core_key, 0);
    axi_read(DONE_OFS, 32'h0);
    axi_read(WOUT_OFS, 32'h0);
    axi_read(ENABLE_OFS, 32'h0);

    // Key load and start.
    axi_write(ENABLE_OFS, 32'h1);
    axi_read(ENABLE_OFS, 32'h1);
    s0 = start_count;
    for (int i = 0; i < 5; i++) axi_write(KEY_OFS, key_a_words[i]);
    chk("no_start_before_6th", start_count - s0, 0);
    axi_write(KEY_OFS, key_a_words[5]);
    chk("start_after_6th", start_count - s0, 1);
    chk("core_key_a", core_key, KEY_A);

    // Result capture and word readout.
    pulse_done({163{1'b1}}, 163'h1);
    axi_read(DONE_OFS, 32'h1);
    for (int i = 0; i < 6; i++) axi_read(WOUT_OFS, (i == 5) ? 32'h7 : 32'hFFFFFFFF);
    for (int i = 0; i < 6; i++) axi_read(ZOUT_OFS, (i == 0) ? 32'h1 : 32'h0);
    axi_read(WOUT_OFS, 32'hFFFFFFFF);
    axi_read(ZOUT_OFS, 32'h1);
    axi_read(5'h1C, 32'h0);
    axi_write(NEXT_K_OFS, 32'hFFFFFFFF);
    axi_read(NEXT_K_OFS, 32'h0);

    // Disable: flags and pointers clear, results and key retained.
    axi_write(ENABLE_OFS, 32'h0);
    axi_read(DONE_OFS, 32'h0);
    axi_read(ZOUT_OFS, 32'h1);
    s0 = start_count;
    for (int i = 0; i < 6; i++) axi_write(KEY_OFS, 32'hDEADBEEF);
    chk("no_start_disabled", start_count - s0, 0);
    chk("core_key_held", core_key, KEY_A);
    pulse_done({163{1'b1}}, {163{1'b1}});
    axi_read(DONE_OFS, 32'h0);
    axi_read(ZOUT_OFS, 32'h0);

    // ENABLE<-0 coinciding with core_done: clear wins.
    axi_write(ENABLE_OFS, 32'h1);
    core_wout = W2; core_zout = W2;
    pulse_done_at_hs = 1'b1;
    axi_write(ENABLE_OFS, 32'h0);
    pulse_done_at_hs = 1'b0;
    axi_read(DONE_OFS, 32'h0);

    // core_done coinciding with a WOUT AR accept: old word returned, pointer reset.
    axi_write(ENABLE_OFS, 32'h1);
    pulse_done(W2, W2);
    axi_read(WOUT_OFS, 32'hA5A50000);
    axi_read(WOUT_OFS, 32'hA5A50001);
    pulse_done_at_hs = 1'b1;
    axi_read(WOUT_OFS, 32'hA5A50002);
    pulse_done_at_hs = 1'b0;
    axi_read(WOUT_OFS, 32'hA5A50000);

    // Write-response back-pressure with a second write waiting.
    bq.push_back(2'b00); bq.push_back(2'b00);
    @(posedge aclk_0); #1 s_axi_bready = 1'b0;
    s_axi_awaddr = NEXT_K_OFS; s_axi_wdata = 32'h0;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    wait_awready("bp_aw_first");
    @(posedge aclk_0); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk_0);
      chk("bp_bvalid_hold", s_axi_bvalid, 1);
      chk("bp_aw_blocked", s_axi_awready, 0);
    end
    @(posedge aclk_0); #1 s_axi_bready = 1'b1;
    wait_awready("bp_aw_second");
    @(posedge aclk_0); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    wait_b_clear();

    // Read-data back-pressure with a second read waiting.
    rq.push_back(32'h1); rq.push_back(32'h1);
    @(posedge aclk_0); #1 s_axi_rready = 1'b0;
    s_axi_araddr = ENABLE_OFS; s_axi_arvalid = 1'b1;
    wait_arready("bp_ar_first");
    @(posedge aclk_0); #1 hold_rdata = s_axi_rdata;
    chk("bp_rdata_first", hold_rdata, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk_0);
      chk("bp_rvalid_hold", s_axi_rvalid, 1);
      chk("bp_rdata_stable", s_axi_rdata, hold_rdata);
      chk("bp_ar_blocked", s_axi_arready, 0);
    end
    @(posedge aclk_0); #1 s_axi_rready = 1'b1;
    wait_arready("bp_ar_second");
    @(posedge aclk_0); #1 s_axi_arvalid = 1'b0;
    wait_r_clear();

    // Reset in the middle of a key load, then a full reload.
    for (int i = 0; i < 3; i++) axi_write(KEY_OFS, key_b_words[i]);
    @(posedge aclk_0); #1 areset_0 = 1'b1;
    @(posedge aclk_0); #1 areset_0 = 1'b0;
    chk("mid_rst_core_key", core_key, 0);
    axi_read(ENABLE_OFS, 32'h0);
    axi_read(DONE_OFS, 32'h0);
    axi_write(ENABLE_OFS, 32'h1);
    s0 = start_count;
    for (int i = 0; i < 5; i++) axi_write(KEY_OFS, key_b_words[i]);
    chk("reload_no_early_start", start_count - s0, 0);
    axi_write(KEY_OFS, key_b_words[5]);
    chk("reload_start", start_count - s0, 1);
    chk("core_key_b", core_key, KEY_B);

    repeat (3) @(posedge aclk_0);
    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
